// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants and divider arithmetic.
package uart_rx_pkg;

   localparam int DEF_UART_BITS  = 8;
   localparam int DEF_CLK_FREQ   = 100_000_000;
   localparam int DEF_BAUD_RATE  = 19200;
   localparam int DEF_OVERSAMPLE = 16;

   // Rounded clocks per oversample tick.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      return (clk_hz + baud * os / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversample tick generator for the UART receiver.
module baud_rate_gen
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 style framing, LSB first, one stop bit.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int UART_BITS  = DEF_UART_BITS,
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx,
   output logic [UART_BITS-1:0] o_rx_data,
   output logic                 o_rx_done,
   output logic                 o_frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (UART_BITS > 2) ? $clog2(UART_BITS) : 1;
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] OS_M1    = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_BITS - 1);

   logic                 tick;
   logic                 rx_m, rx_s, rx_d;
   state_t               state, state_n;
   logic [TW-1:0]        tick_cnt, tick_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [UART_BITS-1:0] shift, shift_n, data_n;
   logic                 done_n, err_n;

   baud_rate_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .o_tick (tick)
   );

   // Flops preset high so a released reset looks like an idle line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         rx_d        <= 1'b1;
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         o_rx_data   <= '0;
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         rx_m        <= i_rx;
         rx_s        <= rx_m;
         rx_d        <= rx_s;
         state       <= state_n;
         tick_cnt    <= tick_n;
         bit_cnt     <= bit_n;
         shift       <= shift_n;
         o_rx_data   <= data_n;
         o_rx_done   <= done_n;
         o_frame_err <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      bit_n   = bit_cnt;
      shift_n = shift;
      data_n  = o_rx_data;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_d && !rx_s) begin
               tick_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == HALF_M1) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  state_n = rx_s ? IDLE : DATA;
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt == OS_M1) begin
                  tick_n  = '0;
                  shift_n = {rx_s, shift[UART_BITS-1:1]};
                  bit_n   = bit_cnt + BW'(1);
                  if (bit_cnt == LAST_BIT) begin
                     state_n = STOP;
                  end
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt == OS_M1) begin
                  tick_n  = '0;
                  state_n = IDLE;
                  if (rx_s) begin
                     data_n = shift;
                     done_n = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Frame-level checker for uart_rx: queued expected strobes with stop-bit timing.
module tb_uart_rx;

   localparam int     CLK_FREQ = 1536000;
   localparam int     BAUD     = 19200;
   localparam int     OS       = 16;
   localparam int     DIV      = (CLK_FREQ + BAUD * OS / 2) / (BAUD * OS);
   localparam int     BIT      = DIV * OS;
   localparam longint PER      = 10;
   localparam longint TOL      = longint'(DIV + 6) * PER;

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic       i_rx = 1'b1;
   logic [7:0] o_rx_data;
   logic       o_rx_done;
   logic       o_frame_err;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      longint     due;
   } ev_t;

   ev_t        exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         n_done = 0;
   int         n_err = 0;
   int         lenient = 0;
   logic [7:0] model_data = 8'h00;

   uart_rx #(
      .UART_BITS  (8),
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (i_rx),
      .o_rx_data   (o_rx_data),
      .o_rx_done   (o_rx_done),
      .o_frame_err (o_frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A frame's strobe is due at the middle of its stop bit.
   task automatic send(input logic [7:0] b, input bit stop_bit);
      ev_t ev;
      i_rx      = 1'b0;
      ev.is_err = !stop_bit;
      ev.data   = b;
      ev.due    = longint'($time) + longint'(BIT) * PER * 19 / 2;
      exp_q.push_back(ev);
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         idle(BIT);
      end
      i_rx = stop_bit;
      idle(BIT);
      i_rx = 1'b1;
   endtask

   initial begin : compare
      bit         pd;
      bit         pe;
      logic [7:0] pdata;
      ev_t        ev;
      longint     now;
      pd    = 1'b0;
      pe    = 1'b0;
      pdata = 8'h00;
      forever begin
         @(negedge clk);
         now = longint'($time);
         if (!rst) begin
            pd         = 1'b0;
            pe         = 1'b0;
            pdata      = o_rx_data;
            model_data = 8'h00;
         end else begin
            if (o_rx_done || o_frame_err) begin
               check("strobes exclusive", 32'(o_rx_done & o_frame_err), 32'd0);
               check("done width", 32'(o_rx_done & pd), 32'd0);
               check("err width", 32'(o_frame_err & pe), 32'd0);
               if (exp_q.size() == 0) begin
                  if (o_frame_err && !o_rx_done && lenient > 0) begin
                     lenient--;
                  end else begin
                     check("unexpected pulse", {30'd0, o_rx_done, o_frame_err}, 32'd0);
                  end
               end else begin
                  ev = exp_q.pop_front();
                  check("pulse kind", 32'(o_frame_err), 32'(ev.is_err));
                  check("pulse timing",
                        32'((now >= ev.due - TOL) && (now <= ev.due + TOL)), 32'd1);
                  if (!ev.is_err) begin
                     model_data = ev.data;
                     check("rx data", 32'(o_rx_data), 32'(ev.data));
                  end
               end
            end
            if (o_rx_data !== pdata) begin
               check("data moves only with done", 32'(o_rx_done), 32'd1);
            end
            if (o_frame_err) begin
               check("data held on err", 32'(o_rx_data), 32'(model_data));
            end
            if (exp_q.size() > 0 && now > exp_q[0].due + TOL) begin
               check("missing pulse", 32'(o_rx_done | o_frame_err), 32'd1);
               void'(exp_q.pop_front());
            end
            n_done += int'(o_rx_done);
            n_err  += int'(o_frame_err);
            pd    = o_rx_done;
            pe    = o_frame_err;
            pdata = o_rx_data;
         end
      end
   end

   initial begin : stim
      rst  = 1'b0;
      i_rx = 1'b1;
      idle(3);
      check("reset data", 32'(o_rx_data), 32'd0);
      check("reset done", 32'(o_rx_done), 32'd0);
      check("reset err", 32'(o_frame_err), 32'd0);
      rst = 1'b1;
      idle(BIT);

      send(8'h55, 1'b1);
      idle(BIT);
      check("single 55 data", 32'(o_rx_data), 32'h55);
      check("single 55 dones", 32'(n_done), 32'd1);
      check("single 55 errs", 32'(n_err), 32'd0);

      send(8'hA3, 1'b1);
      send(8'h0F, 1'b1);
      idle(BIT);
      check("b2b last data", 32'(o_rx_data), 32'h0F);
      check("b2b dones", 32'(n_done), 32'd3);

      i_rx = 1'b0;
      idle(4 * DIV);
      i_rx = 1'b1;
      idle(2 * BIT);
      check("glitch dones", 32'(n_done), 32'd3);
      check("glitch errs", 32'(n_err), 32'd0);
      send(8'h3C, 1'b1);
      idle(BIT);
      check("post-glitch data", 32'(o_rx_data), 32'h3C);
      check("post-glitch dones", 32'(n_done), 32'd4);

      send(8'h55, 1'b1);
      send(8'h81, 1'b0);
      idle(2 * BIT);
      check("bad stop errs", 32'(n_err), 32'd1);
      check("bad stop data kept", 32'(o_rx_data), 32'h55);
      check("bad stop dones", 32'(n_done), 32'd5);

      // 0xF0 aborted by reset in the middle of bit 4.
      i_rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 4; i++) begin
         i_rx = 1'b0;
         idle(BIT);
      end
      i_rx = 1'b1;
      idle(BIT / 2);
      rst = 1'b0;
      idle(3);
      check("mid-frame reset data", 32'(o_rx_data), 32'd0);
      rst = 1'b1;
      idle(BIT - BIT / 2 - 3);
      idle(4 * BIT);
      idle(2 * BIT);
      check("aborted frame dones", 32'(n_done), 32'd5);
      check("aborted frame errs", 32'(n_err), 32'd1);
      check("aborted frame data", 32'(o_rx_data), 32'd0);
      send(8'h12, 1'b1);
      idle(BIT);
      check("post-reset data", 32'(o_rx_data), 32'h12);
      check("post-reset dones", 32'(n_done), 32'd6);

      lenient = 1;
      rst     = 1'b0;
      i_rx    = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(20 * BIT);
      check("held-low dones", 32'(n_done), 32'd6);
      check("held-low errs at most one", 32'(n_err <= 2), 32'd1);
      check("held-low data", 32'(o_rx_data), 32'd0);
      i_rx = 1'b1;
      idle(2 * BIT);
      lenient = 0;
      send(8'h5A, 1'b1);
      idle(2 * BIT);
      check("recovered data", 32'(o_rx_data), 32'h5A);
      check("recovered dones", 32'(n_done), 32'd7);
      check("all strobes seen", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
